// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control FSM for the RV32I core.
// Fetches over a req/ack handshake, decodes, and sequences the datapath
// through EXEC / MEM / WB, driving the ALU code and every mux select.
module multicycle_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int CTRL_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  imem_req,
   input  logic                  imem_ack,
   input  logic [DATA_WIDTH-1:0] instr,
   output logic                  dmem_req,
   output logic                  dmem_we,
   input  logic                  dmem_ack,
   output logic [CTRL_WIDTH-1:0] alu_ctrl,
   input  logic                  alu_zero,
   output logic                  alu_src_b,
   output logic [1:0]            imm_sel,
   output logic                  ir_write,
   output logic                  reg_write,
   output logic [1:0]            result_sel,
   output logic                  pc_write,
   output logic                  pc_sel,
   output logic                  trap
);

   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [CTRL_WIDTH-1:0] ALU_ADD = CTRL_WIDTH'(0);
   localparam logic [CTRL_WIDTH-1:0] ALU_SUB = CTRL_WIDTH'(1);
   localparam logic [CTRL_WIDTH-1:0] ALU_AND = CTRL_WIDTH'(2);
   localparam logic [CTRL_WIDTH-1:0] ALU_OR  = CTRL_WIDTH'(3);
   localparam logic [CTRL_WIDTH-1:0] ALU_XOR = CTRL_WIDTH'(4);
   localparam logic [CTRL_WIDTH-1:0] ALU_SLT = CTRL_WIDTH'(5);
   localparam logic [CTRL_WIDTH-1:0] ALU_SLL = CTRL_WIDTH'(6);
   localparam logic [CTRL_WIDTH-1:0] ALU_SRL = CTRL_WIDTH'(7);
   localparam logic [CTRL_WIDTH-1:0] ALU_SRA = CTRL_WIDTH'(8);

   localparam logic [1:0] IMM_I = 2'd0;
   localparam logic [1:0] IMM_S = 2'd1;
   localparam logic [1:0] IMM_B = 2'd2;
   localparam logic [1:0] IMM_J = 2'd3;

   state_t      state;
   state_t      next_state;
   logic        active;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        funct7b5;
   logic        legal;
   logic [CTRL_WIDTH-1:0] alu_code;
   logic [CTRL_WIDTH-1:0] br_code;
   logic        br_taken;
   logic        unused_instr_bits;

   // rd, rs1, rs2 and the immediate are consumed by the datapath, not here
   assign unused_instr_bits = ^{instr[DATA_WIDTH-1:31], instr[29:15], instr[11:7]};

   // State register; 'active' holds every output low until the first clock
   // after reset release, so the first fetch request follows that edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= FETCH;
         active <= 1'b0;
      end else begin
         state  <= next_state;
         active <= 1'b1;
      end
   end

   // The instruction is only valid on the ack cycle, so its decode fields are
   // captured then (alongside ir_write) and used from DECODE onwards
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opcode   <= 7'd0;
         funct3   <= 3'd0;
         funct7b5 <= 1'b0;
      end else if (active && state == FETCH && imem_ack) begin
         opcode   <= instr[6:0];
         funct3   <= instr[14:12];
         funct7b5 <= instr[30];
      end
   end

   // Instruction legality plus ALU/branch code lookup from the latched fields
   always_comb begin
      legal    = 1'b0;
      alu_code = ALU_ADD;
      br_code  = ALU_ADD;
      case (opcode)
         OP_R, OP_I, OP_BR: legal = (funct3 != 3'b010) && (funct3 != 3'b011);
         OP_LW, OP_SW:      legal = (funct3 == 3'b010);
         OP_JAL:            legal = 1'b1;
         default:           legal = 1'b0;
      endcase
      case (funct3)
         3'b000:  alu_code = (opcode == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
         3'b001:  alu_code = ALU_SLL;
         3'b100:  alu_code = ALU_XOR;
         3'b101:  alu_code = funct7b5 ? ALU_SRA : ALU_SRL;
         3'b110:  alu_code = ALU_OR;
         3'b111:  alu_code = ALU_AND;
         default: alu_code = ALU_ADD;
      endcase
      case (funct3)
         3'b100:  br_code = ALU_OR;
         3'b101:  br_code = ALU_SUB;
         3'b110:  br_code = ALU_SLT;
         3'b111:  br_code = ALU_AND;
         default: br_code = ALU_ADD;
      endcase
      br_taken = (funct3 == 3'b001) ? !alu_zero : alu_zero;
   end

   // Next-state sequencing; TRAP is only left through reset
   always_comb begin
      next_state = state;
      case (state)
         FETCH:  if (active && imem_ack) next_state = DECODE;
         DECODE: next_state = legal ? EXEC : TRAP;
         EXEC: begin
            case (opcode)
               OP_BR:        next_state = FETCH;
               OP_LW, OP_SW: next_state = MEM;
               default:      next_state = WB;
            endcase
         end
         MEM:    if (dmem_ack) next_state = (opcode == OP_LW) ? WB : FETCH;
         WB:     next_state = FETCH;
         TRAP:   next_state = TRAP;
         default: next_state = FETCH;
      endcase
   end

   // Output decode from registered state and latched fields; only ir_write,
   // the branch PC controls and the SW pc_write look at handshake/flag inputs
   always_comb begin
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      alu_ctrl   = ALU_ADD;
      alu_src_b  = 1'b0;
      imm_sel    = IMM_I;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      result_sel = 2'd0;
      pc_write   = 1'b0;
      pc_sel     = 1'b0;
      trap       = 1'b0;
      if (active) begin
         case (state)
            FETCH: begin
               imem_req = 1'b1;
               ir_write = imem_ack;
            end
            EXEC: begin
               case (opcode)
                  OP_R, OP_I: begin
                     alu_ctrl  = alu_code;
                     alu_src_b = (opcode == OP_I);
                  end
                  OP_LW: begin
                     alu_src_b = 1'b1;
                     imm_sel   = IMM_I;
                  end
                  OP_SW: begin
                     alu_src_b = 1'b1;
                     imm_sel   = IMM_S;
                  end
                  OP_BR: begin
                     alu_ctrl = br_code;
                     imm_sel  = IMM_B;
                     pc_write = 1'b1;
                     pc_sel   = br_taken;
                  end
                  OP_JAL:  imm_sel = IMM_J;
                  default: ;
               endcase
            end
            MEM: begin
               alu_src_b = 1'b1;
               imm_sel   = (opcode == OP_SW) ? IMM_S : IMM_I;
               dmem_req  = 1'b1;
               dmem_we   = (opcode == OP_SW);
               pc_write  = (opcode == OP_SW) && dmem_ack;
            end
            WB: begin
               reg_write = 1'b1;
               pc_write  = 1'b1;
               case (opcode)
                  OP_LW:  result_sel = 2'd1;
                  OP_JAL: begin
                     result_sel = 2'd2;
                     pc_sel     = 1'b1;
                  end
                  OP_R, OP_I: begin
                     alu_ctrl  = alu_code;
                     alu_src_b = (opcode == OP_I);
                  end
                  default: ;
               endcase
            end
            TRAP:    trap = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed scenario bench for multicycle_ctrl.
module tb_multicycle_ctrl;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic        imem_ack;
   logic [31:0] instr;
   logic        dmem_req;
   logic        dmem_we;
   logic        dmem_ack;
   logic [3:0]  alu_ctrl;
   logic        alu_zero;
   logic        alu_src_b;
   logic [1:0]  imm_sel;
   logic        ir_write;
   logic        reg_write;
   logic [1:0]  result_sel;
   logic        pc_write;
   logic        pc_sel;
   logic        trap;

   int tests_run = 0;
   int tests_failed = 0;

   localparam logic [31:0] I_SUB  = 32'h402081B3;
   localparam logic [31:0] I_SRAI = 32'h4020D193;
   localparam logic [31:0] I_JAL  = 32'h000000EF;
   localparam logic [31:0] I_BLT  = 32'h0020C063;
   localparam logic [31:0] I_BNE  = 32'h00209063;
   localparam logic [31:0] I_BGEU = 32'h0020F063;
   localparam logic [31:0] I_LW   = 32'h0000A283;
   localparam logic [31:0] I_SW   = 32'h0020A023;
   localparam logic [31:0] I_BADOP = 32'h0000007F;
   localparam logic [31:0] I_RSLT  = 32'h0020A1B3;

   multicycle_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_ack(imem_ack), .instr(instr),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
      .alu_ctrl(alu_ctrl), .alu_zero(alu_zero), .alu_src_b(alu_src_b),
      .imm_sel(imm_sel), .ir_write(ir_write), .reg_write(reg_write),
      .result_sel(result_sel), .pc_write(pc_write), .pc_sel(pc_sel),
      .trap(trap)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   // Advance to just after the next rising edge; inputs change here and
   // outputs are sampled #1 later
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Hold reset for two cycles, release, and land in the first FETCH cycle
   task automatic do_reset();
      rst_n = 1'b0;
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      alu_zero = 1'b0;
      instr = '0;
      next_cycle();
      next_cycle();
      rst_n = 1'b1;
      next_cycle();
   endtask

   // Present one instruction with an immediate ack; returns ir_write/imem_req
   // as seen on the ack cycle and leaves the bench in DECODE
   task automatic fetch(input logic [31:0] word, output logic irw, output logic req);
      instr = word;
      imem_ack = 1'b1;
      #1;
      irw = ir_write;
      req = imem_req;
      next_cycle();
      imem_ack = 1'b0;
      instr = '0;
   endtask

   task automatic test_reset();
      logic [16:0] outs;
      rst_n = 1'b0;
      imem_ack = 1'b1;
      dmem_ack = 1'b1;
      alu_zero = 1'b1;
      instr = I_SUB;
      next_cycle();
      next_cycle();
      #1;
      outs = {imem_req, dmem_req, dmem_we, alu_ctrl, alu_src_b, imm_sel, ir_write,
              reg_write, result_sel, pc_write, pc_sel, trap};
      tests_run++;
      if (outs !== 17'd0) begin
         tests_failed++;
         $display("[TB] FAIL reset_outputs: got %05h expected 00000", outs);
      end
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      alu_zero = 1'b0;
      instr = '0;
      rst_n = 1'b1;
      #1;
      tests_run++;
      if (imem_req !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_release_same_cycle: imem_req got %b expected 0", imem_req);
      end
      next_cycle();
      #1;
      tests_run++;
      if (imem_req !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL first_fetch_req: imem_req got %b expected 1", imem_req);
      end
   endtask

   task automatic test_r_sub();
      logic irw, req;
      do_reset();
      fetch(I_SUB, irw, req);
      tests_run++;
      if ({irw, req} !== 2'b11) begin
         tests_failed++;
         $display("[TB] FAIL sub_fetch: ir_write,imem_req got %b%b expected 11", irw, req);
      end
      #1;
      tests_run++;
      if ({imem_req, ir_write, reg_write, pc_write} !== 4'b0000) begin
         tests_failed++;
         $display("[TB] FAIL sub_decode_quiet: got %b expected 0000",
                  {imem_req, ir_write, reg_write, pc_write});
      end
      next_cycle();
      #1;
      tests_run++;
      if ({alu_ctrl, alu_src_b, reg_write, pc_write} !== {4'd1, 3'b000}) begin
         tests_failed++;
         $display("[TB] FAIL sub_exec: alu_ctrl=%0d src_b=%b rw=%b pcw=%b expected 1 0 0 0",
                  alu_ctrl, alu_src_b, reg_write, pc_write);
      end
      next_cycle();
      #1;
      tests_run++;
      if ({reg_write, pc_write, pc_sel, result_sel} !== 5'b11000) begin
         tests_failed++;
         $display("[TB] FAIL sub_wb: rw=%b pcw=%b pcsel=%b rsel=%0d expected 1 1 0 0",
                  reg_write, pc_write, pc_sel, result_sel);
      end
      next_cycle();
      #1;
      tests_run++;
      if ({imem_req, reg_write} !== 2'b10) begin
         tests_failed++;
         $display("[TB] FAIL sub_latency: imem_req=%b reg_write=%b 4 cycles after fetch, expected 1 0",
                  imem_req, reg_write);
      end
   endtask

   task automatic test_srai_jal();
      logic irw, req;
      do_reset();
      fetch(I_SRAI, irw, req);
      next_cycle();
      #1;
      tests_run++;
      if ({alu_ctrl, alu_src_b} !== {4'd8, 1'b1}) begin
         tests_failed++;
         $display("[TB] FAIL srai_exec: alu_ctrl=%0d src_b=%b expected 8 1", alu_ctrl, alu_src_b);
      end
      next_cycle();
      next_cycle();
      fetch(I_JAL, irw, req);
      tests_run++;
      if (req !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL jal_fetch: imem_req got %b expected 1", req);
      end
      next_cycle();
      #1;
      tests_run++;
      if ({imm_sel, pc_write, reg_write} !== 4'b1100) begin
         tests_failed++;
         $display("[TB] FAIL jal_exec: imm_sel=%0d pcw=%b rw=%b expected 3 0 0", imm_sel, pc_write, reg_write);
      end
      next_cycle();
      #1;
      tests_run++;
      if ({reg_write, pc_write, pc_sel, result_sel} !== 5'b11110) begin
         tests_failed++;
         $display("[TB] FAIL jal_wb: rw=%b pcw=%b pcsel=%b rsel=%0d expected 1 1 1 2",
                  reg_write, pc_write, pc_sel, result_sel);
      end
      next_cycle();
      #1;
      tests_run++;
      if (imem_req !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL jal_latency: imem_req got %b expected 1", imem_req);
      end
   endtask

   task automatic test_branch();
      logic [31:0] words [4] = '{I_BLT, I_BLT, I_BNE, I_BGEU};
      logic        zeros [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      logic [3:0]  codes [4] = '{4'd3, 4'd3, 4'd0, 4'd2};
      logic        sels  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
      logic irw, req;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         fetch(words[i], irw, req);
         next_cycle();
         alu_zero = zeros[i];
         #1;
         tests_run++;
         if ({alu_ctrl, pc_write, pc_sel, imm_sel, reg_write} !== {codes[i], 1'b1, sels[i], 2'd2, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL branch_exec[%0d]: alu=%0d pcw=%b pcsel=%b imm=%0d rw=%b expected %0d 1 %b 2 0",
                     i, alu_ctrl, pc_write, pc_sel, imm_sel, reg_write, codes[i], sels[i]);
         end
         next_cycle();
         alu_zero = 1'b0;
         #1;
         tests_run++;
         if ({imem_req, reg_write, pc_write} !== 3'b100) begin
            tests_failed++;
            $display("[TB] FAIL branch_latency[%0d]: imem_req=%b rw=%b pcw=%b expected 1 0 0",
                     i, imem_req, reg_write, pc_write);
         end
      end
   endtask

   task automatic test_lw_wait();
      logic irw, req;
      do_reset();
      fetch(I_LW, irw, req);
      next_cycle();
      #1;
      tests_run++;
      if ({alu_ctrl, alu_src_b, imm_sel} !== {4'd0, 1'b1, 2'd0}) begin
         tests_failed++;
         $display("[TB] FAIL lw_exec: alu=%0d src_b=%b imm=%0d expected 0 1 0", alu_ctrl, alu_src_b, imm_sel);
      end
      next_cycle();
      for (int i = 0; i < 4; i++) begin
         dmem_ack = (i == 3);
         #1;
         tests_run++;
         if ({dmem_req, dmem_we, reg_write, pc_write} !== 4'b1000) begin
            tests_failed++;
            $display("[TB] FAIL lw_mem[%0d]: req=%b we=%b rw=%b pcw=%b expected 1 0 0 0",
                     i, dmem_req, dmem_we, reg_write, pc_write);
         end
         next_cycle();
      end
      dmem_ack = 1'b0;
      #1;
      tests_run++;
      if ({reg_write, pc_write, result_sel, dmem_req} !== 5'b11010) begin
         tests_failed++;
         $display("[TB] FAIL lw_wb: rw=%b pcw=%b rsel=%0d dreq=%b expected 1 1 1 0",
                  reg_write, pc_write, result_sel, dmem_req);
      end
      next_cycle();
      #1;
      tests_run++;
      if (imem_req !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL lw_latency: imem_req got %b 8 cycles after fetch, expected 1", imem_req);
      end
   endtask

   task automatic test_sw();
      logic irw, req;
      do_reset();
      fetch(I_SW, irw, req);
      next_cycle();
      #1;
      tests_run++;
      if ({alu_ctrl, alu_src_b, imm_sel} !== {4'd0, 1'b1, 2'd1}) begin
         tests_failed++;
         $display("[TB] FAIL sw_exec: alu=%0d src_b=%b imm=%0d expected 0 1 1", alu_ctrl, alu_src_b, imm_sel);
      end
      next_cycle();
      #1;
      tests_run++;
      if ({dmem_req, dmem_we, pc_write} !== 3'b110) begin
         tests_failed++;
         $display("[TB] FAIL sw_mem_wait: req=%b we=%b pcw=%b expected 1 1 0", dmem_req, dmem_we, pc_write);
      end
      next_cycle();
      dmem_ack = 1'b1;
      #1;
      tests_run++;
      if ({dmem_req, dmem_we, pc_write, pc_sel, reg_write} !== 5'b11100) begin
         tests_failed++;
         $display("[TB] FAIL sw_mem_ack: req=%b we=%b pcw=%b pcsel=%b rw=%b expected 1 1 1 0 0",
                  dmem_req, dmem_we, pc_write, pc_sel, reg_write);
      end
      next_cycle();
      dmem_ack = 1'b0;
      #1;
      tests_run++;
      if ({imem_req, reg_write, pc_write} !== 3'b100) begin
         tests_failed++;
         $display("[TB] FAIL sw_no_wb: imem_req=%b rw=%b pcw=%b expected 1 0 0", imem_req, reg_write, pc_write);
      end
   endtask

   task automatic test_trap();
      logic [31:0] words [2] = '{I_BADOP, I_RSLT};
      logic irw, req;
      int activity;
      for (int t = 0; t < 2; t++) begin
         do_reset();
         fetch(words[t], irw, req);
         next_cycle();
         #1;
         tests_run++;
         if ({trap, imem_req} !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL trap_enter[%0d]: trap=%b imem_req=%b expected 1 0", t, trap, imem_req);
         end
         activity = 0;
         for (int c = 0; c < 6; c++) begin
            imem_ack = 1'b1;
            dmem_ack = c[0];
            instr = I_SUB;
            #1;
            if (imem_req || dmem_req || ir_write || reg_write || pc_write || !trap) activity++;
            next_cycle();
         end
         imem_ack = 1'b0;
         dmem_ack = 1'b0;
         instr = '0;
         tests_run++;
         if (activity !== 0) begin
            tests_failed++;
            $display("[TB] FAIL trap_sticky[%0d]: %0d cycles with activity or trap low, expected 0", t, activity);
         end
      end
      do_reset();
      #1;
      tests_run++;
      if ({trap, imem_req} !== 2'b01) begin
         tests_failed++;
         $display("[TB] FAIL trap_exit_reset: trap=%b imem_req=%b expected 0 1", trap, imem_req);
      end
   endtask

   task automatic test_reset_mid_lw();
      logic irw, req;
      int rw_seen;
      do_reset();
      fetch(I_LW, irw, req);
      next_cycle();
      next_cycle();
      #1;
      tests_run++;
      if (dmem_req !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL midlw_in_mem: dmem_req got %b expected 1", dmem_req);
      end
      rst_n = 1'b0;
      #1;
      tests_run++;
      if ({dmem_req, reg_write, pc_write} !== 3'b000) begin
         tests_failed++;
         $display("[TB] FAIL midlw_async_drop: dreq=%b rw=%b pcw=%b expected 0 0 0", dmem_req, reg_write, pc_write);
      end
      dmem_ack = 1'b1;
      rw_seen = 0;
      for (int c = 0; c < 3; c++) begin
         next_cycle();
         #1;
         if (reg_write || pc_write) rw_seen++;
      end
      dmem_ack = 1'b0;
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         if (c == 0) begin
            #1;
            if (reg_write || pc_write) rw_seen++;
         end
      end
      next_cycle();
      #1;
      tests_run++;
      if ({imem_req, rw_seen != 0} !== 2'b10) begin
         tests_failed++;
         $display("[TB] FAIL midlw_resume: imem_req=%b write_strobe_cycles=%0d expected 1 0", imem_req, rw_seen);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      alu_zero = 1'b0;
      instr = '0;
      test_reset();
      test_r_sub();
      test_srai_jal();
      test_branch();
      test_lw_wait();
      test_sw();
      test_trap();
      test_reset_mid_lw();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
